load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  pipeline presents a memory request.
REQ-005 req_write  input  1  1 = store, 0 = load.
REQ-006 funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  store data; low byte/half used for SB/SH.
REQ-009 req_ready  output  1  unit idle and able to accept a request.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_err  output  1  request rejected (misaligned or illegal funct3); valid with resp_valid.
REQ-012 rdata  output  32  extended load result; valid with resp_valid.
REQ-013 mem_addr  output  32  word index to DataMemory = {2'b00, addr[31:2]}.
REQ-014 mem_read / mem_write  output  1 each  DataMemory MemRead / MemWrite.
REQ-015 mem_wdata  output  32  full word to DataMemory Write_data.
REQ-016 mem_rdata  input  32  DataMemory MemData_out.

Function
REQ-017 SHALL implement FSM states IDLE, RD, CAP, WR, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid & req_ready at a rising edge, latching req_write, funct3, addr, wdata.
REQ-019 Error check at accept: H/HU with addr[0]=1, W with addr[1:0]!=0, funct3 in {011,110,111}, or store with funct3 in {100,101} -> RESP with resp_err=1; no memory strobe SHALL be asserted.
REQ-020 Load: IDLE -> RD -> CAP -> RESP; resp_valid 3 cycles after accept.
REQ-021 SW: IDLE -> WR -> RESP; mem_write=1 in WR with mem_wdata=wdata; resp_valid 2 cycles after accept.
REQ-022 SB/SH (read-modify-write): IDLE -> RD -> CAP -> WR -> RESP; resp_valid 4 cycles after accept.
REQ-023 mem_read SHALL be 1 in RD and CAP, 0 otherwise; mem_write SHALL be 1 only in WR.
REQ-024 mem_addr SHALL hold the latched word index throughout RD, CAP, WR; 0 in IDLE.
REQ-025 In CAP, mem_rdata SHALL be captured into an internal word register.
REQ-026 Byte lane = addr[1:0]; half lane = addr[1]; lane 0 = bits [7:0] / [15:0] (little-endian).
REQ-027 Merge: WR word = captured word with only the selected lane replaced by wdata[7:0] (SB) or wdata[15:0] (SH); other bits unchanged.
REQ-028 Load extension: B/H sign-extend selected lane; BU/HU zero-extend; W passes word unchanged.
REQ-029 RESP lasts exactly one cycle then returns to IDLE; new request acceptable the following cycle.
REQ-030 rdata SHALL hold its last value until the next load completes; on stores and errors rdata = 0 during resp_valid.
REQ-031 req_valid in any non-IDLE state SHALL be ignored (caller holds it until req_ready).

Reset
REQ-032 Reset SHALL force IDLE, req_ready=1, resp_valid=0, resp_err=0, rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-033 Reset asserted in any state, including WR, SHALL take priority: mem_write is 0 from the reset edge onward and no response is issued for the aborted request.

Verification
REQ-034 SW addr=0x14 wdata=0xABCD1234 -> mem_write=1 with mem_addr=5 one cycle after accept; resp_valid 2 cycles after accept, resp_err=0.
REQ-035 Word 5 = 0xABCD1234; LB addr=0x17 -> rdata=0xFFFFFFAB; LBU addr=0x17 -> 0x000000AB; LH addr=0x14 -> 0x00001234; each resp_valid 3 cycles after accept.
REQ-036 Word 5 = 0xABCD1234; SB addr=0x15 wdata=0x000000EE -> WR writes 0xABCDEE34 4 cycles... write in cycle 3, resp_valid cycle 4; subsequent LW addr=0x14 -> 0xABCDEE34.
REQ-037 LW addr=0x16 and SH addr=0x13 -> resp_valid 1 cycle after accept, resp_err=1, mem_read and mem_write never asserted.
REQ-038 Reset pulsed during WR of an SB -> memory word unchanged on later LW, no resp_valid for the aborted request, req_ready=1 the cycle after reset deasserts.
REQ-039 Back-to-back: req_valid held high for SW then LW -> second request accepted the cycle after first resp_valid, req_ready low in between.

Source files
------------

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_store_unit_if : pipeline request/response and DataMemory bus bundle
// Revision 1.0
// ---------------------------------------------------------------------------
interface load_store_unit_if;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, funct3, addr, wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, rdata,
           mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output req_valid, req_write, funct3, addr, wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, rdata,
           mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_store_unit : RV32I load/store sequencer with read-modify-write SB/SH
// Revision 1.0
// ---------------------------------------------------------------------------
module load_store_unit (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_e;

  state_e      state_q;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic        req_ready_q, resp_valid_q, resp_err_q, mem_read_q, mem_write_q;
  logic [31:0] mem_addr_q, word_q, rdata_q, load_val_q;

  logic        err_d;
  logic [7:0]  byte_d;
  logic [15:0] half_d;
  logic [31:0] ext_d, merge_d;

  always_comb begin
    err_d = 1'b0;
    case (bus.funct3)
      3'b000, 3'b100: err_d = 1'b0;
      3'b001, 3'b101: err_d = bus.addr[0];
      3'b010:         err_d = (bus.addr[1:0] != 2'b00);
      default:        err_d = 1'b1;
    endcase
    if (bus.req_write && bus.funct3[2]) err_d = 1'b1;
  end

  always_comb begin
    byte_d  = bus.mem_rdata[{off_q, 3'b000} +: 8];
    half_d  = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q[1:0])
      2'b00:   ext_d = {{24{byte_d[7] & ~funct3_q[2]}}, byte_d};
      2'b01:   ext_d = {{16{half_d[15] & ~funct3_q[2]}}, half_d};
      default: ext_d = bus.mem_rdata;
    endcase
    merge_d = bus.mem_rdata;
    if (funct3_q[1:0] == 2'b00) merge_d[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else                        merge_d[{off_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      wdata_q      <= 16'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'h0;
      word_q       <= 32'h0;
      rdata_q      <= 32'h0;
      load_val_q   <= 32'h0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          write_q     <= bus.req_write;
          funct3_q    <= bus.funct3;
          off_q       <= bus.addr[1:0];
          wdata_q     <= bus.wdata[15:0];
          req_ready_q <= 1'b0;
          if (err_d) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            rdata_q      <= 32'h0;
          end else if (bus.req_write && bus.funct3 == 3'b010) begin
            state_q     <= WR;
            mem_write_q <= 1'b1;
            mem_addr_q  <= {2'b00, bus.addr[31:2]};
            word_q      <= bus.wdata;
          end else begin
            state_q    <= RD;
            mem_read_q <= 1'b1;
            mem_addr_q <= {2'b00, bus.addr[31:2]};
          end
        end
        RD: state_q <= CAP;
        CAP: begin
          mem_read_q <= 1'b0;
          if (write_q) begin
            // Merge on capture so the WR-cycle write data comes straight from a register
            state_q     <= WR;
            word_q      <= merge_d;
            mem_write_q <= 1'b1;
          end else begin
            state_q      <= RESP;
            word_q       <= bus.mem_rdata;
            rdata_q      <= ext_d;
            load_val_q   <= ext_d;
            resp_valid_q <= 1'b1;
            mem_addr_q   <= 32'h0;
          end
        end
        WR: begin
          state_q      <= RESP;
          mem_write_q  <= 1'b0;
          mem_addr_q   <= 32'h0;
          resp_valid_q <= 1'b1;
          rdata_q      <= 32'h0;
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          req_ready_q  <= 1'b1;
          rdata_q      <= load_val_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.rdata      = rdata_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_read   = mem_read_q;
  // Gated so a reset landing on a WR edge cannot commit the aborted store
  assign bus.mem_write  = mem_write_q & ~reset;
  assign bus.mem_wdata  = word_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_load_store_unit : directed table-driven bench with a 16-word memory
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus ();
  load_store_unit dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] mem [0:15];
  assign bus.mem_rdata = mem[bus.mem_addr[3:0]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[3:0]] <= bus.mem_wdata;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_rd;
    int          exp_wcyc;
    logic [31:0] exp_waddr;
    logic [31:0] exp_wword;
  } vec_t;

  vec_t        vecs[$];
  int          passed = 0;
  int          total  = 0;
  logic [31:0] last_load = 32'h0;

  function automatic vec_t mk_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
    vec_t v;
    v = '{1'b0, f3, a, 32'h0, 1'b0, 3, r, 1'b1, 0, 32'h0, 32'h0};
    return v;
  endfunction

  function automatic vec_t mk_st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] word);
    vec_t v;
    if (f3 == 3'b010) v = '{1'b1, f3, a, d, 1'b0, 2, 32'h0, 1'b0, 1, a >> 2, word};
    else              v = '{1'b1, f3, a, d, 1'b0, 4, 32'h0, 1'b1, 3, a >> 2, word};
    return v;
  endfunction

  function automatic vec_t mk_err(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    vec_t v;
    v = '{wr, f3, a, 32'hDEADBEEF, 1'b1, 1, 32'h0, 1'b0, 0, 32'h0, 32'h0};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Issues one request from a negedge and checks timing, strobes and result.
  task automatic run_req(input vec_t v, input string tag);
    int          n;
    int          lat;
    int          wcyc;
    logic        seen_rd;
    logic [31:0] waddr, wword;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, " ready"}, {31'h0, bus.req_ready}, 32'h1);
    bus.req_valid = 1'b1;
    bus.req_write = v.wr;
    bus.funct3    = v.f3;
    bus.addr      = v.addr;
    bus.wdata     = v.wdata;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1; wcyc = 0; seen_rd = 1'b0; waddr = 32'h0; wword = 32'h0;
    forever begin
      if (bus.mem_read) seen_rd = 1'b1;
      if (bus.mem_write && wcyc == 0) begin
        wcyc = lat; waddr = bus.mem_addr; wword = bus.mem_wdata;
      end
      if (bus.resp_valid || lat >= 8) break;
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, v.exp_lat);
    chk({tag, " resp_err"}, {31'h0, bus.resp_err}, {31'h0, v.exp_err});
    chk({tag, " rdata"}, bus.rdata, v.exp_rdata);
    chk({tag, " mem_read seen"}, {31'h0, seen_rd}, {31'h0, v.exp_rd});
    chk({tag, " write cycle"}, wcyc, v.exp_wcyc);
    if (v.exp_wcyc != 0) begin
      chk({tag, " write addr"}, waddr, v.exp_waddr);
      chk({tag, " write data"}, wword, v.exp_wword);
    end
    if (!v.wr && !v.exp_err) last_load = v.exp_rdata;
    @(negedge clk);
    chk({tag, " resp one cycle"}, {31'h0, bus.resp_valid}, 32'h0);
    chk({tag, " ready after"}, {31'h0, bus.req_ready}, 32'h1);
    chk({tag, " rdata hold"}, bus.rdata, last_load);
  endtask

  initial begin
    int lat;
    int nresp;
    logic seen_wr;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.funct3    = 3'b000;
    bus.addr      = 32'h0;
    bus.wdata     = 32'h0;

    vecs.push_back(mk_st(3'b010, 32'h14, 32'hABCD1234, 32'hABCD1234));
    vecs.push_back(mk_ld(3'b000, 32'h17, 32'hFFFFFFAB));
    vecs.push_back(mk_ld(3'b100, 32'h17, 32'h000000AB));
    vecs.push_back(mk_ld(3'b001, 32'h14, 32'h00001234));
    vecs.push_back(mk_ld(3'b001, 32'h16, 32'hFFFFABCD));
    vecs.push_back(mk_ld(3'b101, 32'h16, 32'h0000ABCD));
    vecs.push_back(mk_ld(3'b010, 32'h14, 32'hABCD1234));
    vecs.push_back(mk_st(3'b000, 32'h15, 32'h000000EE, 32'hABCDEE34));
    vecs.push_back(mk_ld(3'b010, 32'h14, 32'hABCDEE34));
    vecs.push_back(mk_st(3'b001, 32'h16, 32'hFFFF5678, 32'h5678EE34));
    vecs.push_back(mk_ld(3'b010, 32'h14, 32'h5678EE34));
    vecs.push_back(mk_ld(3'b000, 32'h15, 32'hFFFFFFEE));
    vecs.push_back(mk_ld(3'b000, 32'h14, 32'h00000034));
    vecs.push_back(mk_err(1'b0, 3'b010, 32'h16));
    vecs.push_back(mk_err(1'b1, 3'b001, 32'h13));
    vecs.push_back(mk_err(1'b0, 3'b101, 32'h17));
    vecs.push_back(mk_err(1'b0, 3'b011, 32'h00));
    vecs.push_back(mk_err(1'b1, 3'b100, 32'h14));
    vecs.push_back(mk_err(1'b1, 3'b111, 32'h00));
    vecs.push_back(mk_st(3'b010, 32'h00, 32'h00000000, 32'h00000000));
    vecs.push_back(mk_st(3'b000, 32'h03, 32'h123456A5, 32'hA5000000));
    vecs.push_back(mk_ld(3'b100, 32'h03, 32'h000000A5));
    vecs.push_back(mk_ld(3'b000, 32'h03, 32'hFFFFFFA5));
    vecs.push_back(mk_st(3'b001, 32'h02, 32'h00008001, 32'h80010000));
    vecs.push_back(mk_ld(3'b001, 32'h02, 32'hFFFF8001));
    vecs.push_back(mk_ld(3'b010, 32'h00, 32'h80010000));
    vecs.push_back(mk_st(3'b010, 32'h2C, 32'h12345678, 32'h12345678));
    vecs.push_back(mk_ld(3'b101, 32'h2E, 32'h00001234));
    vecs.push_back(mk_err(1'b0, 3'b010, 32'h2D));
    vecs.push_back(mk_ld(3'b000, 32'h2C, 32'h00000078));

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("reset resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("reset resp_err", {31'h0, bus.resp_err}, 32'h0);
    chk("reset rdata", bus.rdata, 32'h0);
    chk("reset strobes", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
    chk("reset mem_addr", bus.mem_addr, 32'h0);
    chk("reset mem_wdata", bus.mem_wdata, 32'h0);

    for (int i = 0; i < vecs.size(); i++) run_req(vecs[i], $sformatf("v%0d", i));

    // Reset landing on the WR cycle of an SB to word 5 (holds 0x5678EE34).
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.funct3 = 3'b000;
    bus.addr = 32'h14; bus.wdata = 32'h00000099;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1; seen_wr = 1'b0;
    while (!seen_wr && lat < 8) begin
      if (bus.mem_write) seen_wr = 1'b1;
      else begin @(negedge clk); lat++; end
    end
    chk("abort reached WR", lat, 3);
    reset = 1'b1;
    #1;
    chk("abort mem_write low", {31'h0, bus.mem_write}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    last_load = 32'h0;
    @(negedge clk);
    chk("abort req_ready", {31'h0, bus.req_ready}, 32'h1);
    nresp = 0;
    repeat (3) begin
      if (bus.resp_valid) nresp++;
      @(negedge clk);
    end
    chk("abort no resp", nresp, 0);
    run_req(mk_ld(3'b010, 32'h14, 32'h5678EE34), "abort LW");

    // Back-to-back: req_valid held from SW through LW.
    chk("b2b ready", {31'h0, bus.req_ready}, 32'h1);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.funct3 = 3'b010;
    bus.addr = 32'h20; bus.wdata = 32'h0BADF00D;
    @(posedge clk);
    @(negedge clk);
    chk("b2b c1 ready", {31'h0, bus.req_ready}, 32'h0);
    bus.req_write = 1'b0;
    @(negedge clk);
    chk("b2b c2 resp", {30'h0, bus.resp_valid, bus.req_ready}, 32'h2);
    @(negedge clk);
    chk("b2b c3 ready", {30'h0, bus.resp_valid, bus.req_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 8) begin @(negedge clk); lat++; end
    chk("b2b LW latency", lat, 3);
    chk("b2b LW rdata", bus.rdata, 32'h0BADF00D);
    chk("b2b LW err", {31'h0, bus.resp_err}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
